seg7_reader: RTL and testbench

Monitor that reads a 7-segment segment bus (the pattern a hex-digit display driver produces) and recovers the hex digit shown. It filters transient patterns, flags illegal patterns, checks that successive digits follow the +1 mod 16 count sequence, and flags a display that has stopped advancing. It sits on the same segment bus as a display counter and serves as a self-check / loopback observer.

---
 rtl/seg7_pkg.sv | 38 +++
 rtl/seg7_inv.sv | 41 ++++
 rtl/seg7_reader.sv | 197 +++++++++++++++++++
 tb/tb_seg7_reader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment pattern table and reader FSM state type
//
// Purpose: one place for the hex-digit segment patterns so the display
// driver and the loopback reader agree on the same encoding.
// Bit order of every pattern: bit0=a, bit1=b, ... bit6=g, 1 = segment lit.
// Contents:
//   SEG_0 .. SEG_F  patterns for hex digits 0..F (b and d are lower case)
//   SEG_BLANK       all segments dark
//   seg7_state_t    reader FSM state (NO_REF / TRACK)

package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // NO_REF: no legal previous digit to compare against.
  // TRACK:  prev holds the last legal digit; the next one must be prev+1.
  typedef enum logic {
    NO_REF = 1'b0,
    TRACK  = 1'b1
  } seg7_state_t;

endpackage

// File: rtl/seg7_inv.sv
// rtl/seg7_inv.sv - combinational segment pattern to hex digit decoder
//
// Purpose: inverse of the display driver's digit->segment table.
// Ports:
//   seg    in  7  segment pattern (bit0=a .. bit6=g, active-high)
//   legal  out 1  pattern is one of the 16 hex-digit patterns
//   digit  out 4  decoded digit (0 when not legal)

module seg7_inv
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic [3:0] digit
);

  always_comb begin
    legal = 1'b1;
    digit = 4'h0;
    case (seg)
      SEG_0:   digit = 4'h0;
      SEG_1:   digit = 4'h1;
      SEG_2:   digit = 4'h2;
      SEG_3:   digit = 4'h3;
      SEG_4:   digit = 4'h4;
      SEG_5:   digit = 4'h5;
      SEG_6:   digit = 4'h6;
      SEG_7:   digit = 4'h7;
      SEG_8:   digit = 4'h8;
      SEG_9:   digit = 4'h9;
      SEG_A:   digit = 4'hA;
      SEG_B:   digit = 4'hB;
      SEG_C:   digit = 4'hC;
      SEG_D:   digit = 4'hD;
      SEG_E:   digit = 4'hE;
      SEG_F:   digit = 4'hF;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// rtl/seg7_reader.sv - 7-segment bus monitor recovering and checking hex digits
//
// Purpose: watches a segment bus driven by a hex counter display, debounces
// transient patterns, decodes the digit, flags illegal patterns, checks the
// +1 mod 16 count sequence and flags a display that stopped advancing.
// Optional feature macro: SEG7_READER_BLANK_EN (pattern 00 treated as a legal
// blank: no pulse, no error, breaks the sequence reference).
// Parameters:
//   STABLE_CYCLES  samples a pattern must hold before acceptance (>= 2)
//   STALL_LIMIT    cycles without acceptance before stall asserts
// Ports:
//   clk            in  1  clock, rising edge
//   rst            in  1  synchronous active-high reset
//   seg_in         in  7  segment pattern, bit0=a .. bit6=g, 1 = lit
//   digit_out      out 4  last accepted legal digit
//   digit_valid    out 1  pulse per accepted legal digit
//   invalid_pulse  out 1  pulse per accepted illegal pattern
//   seq_err        out 1  pulse when an accepted digit is not prev+1
//   stall          out 1  level, no acceptance for STALL_LIMIT cycles
//   err_count      out 8  saturating count of invalid_pulse + seq_err events

module seg7_reader
  import seg7_pkg::*;
#(
  parameter int          STABLE_CYCLES = 4,
  parameter logic [23:0] STALL_LIMIT   = 24'd12000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  output logic [3:0] digit_out,
  output logic       digit_valid,
  output logic       invalid_pulse,
  output logic       seq_err,
  output logic       stall,
  output logic [7:0] err_count
);

  localparam int            CW       = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] STAB_MAX = CW'(STABLE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Input sample and stability qualification
  // ---------------------------------------------------------------------------
  logic [6:0]    seg_q;
  logic [CW-1:0] stab_cnt;
  logic [6:0]    last_pat;
  logic          have_last;
  logic          accept;

  // stab_cnt counts how many further samples matched the one captured in
  // seg_q; reaching STAB_MAX means seg_q has been seen STABLE_CYCLES times.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q    <= 7'h00;
      stab_cnt <= '0;
    end else begin
      seg_q <= seg_in;
      if (seg_in != seg_q) begin
        stab_cnt <= '0;
      end else if (stab_cnt != STAB_MAX) begin
        stab_cnt <= stab_cnt + 1'b1;
      end
    end
  end

  // Comparing against the last accepted pattern makes each stable pattern
  // fire once, however long it is held afterwards.
  assign accept = (stab_cnt == STAB_MAX) && (!have_last || (seg_q != last_pat));

  always_ff @(posedge clk) begin
    if (rst) begin
      have_last <= 1'b0;
      last_pat  <= 7'h00;
    end else if (accept) begin
      have_last <= 1'b1;
      last_pat  <= seg_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Pattern decode
  // ---------------------------------------------------------------------------
  logic       pat_legal;
  logic [3:0] pat_digit;
  logic       is_blank;

  seg7_inv u_inv (
    .seg   (seg_q),
    .legal (pat_legal),
    .digit (pat_digit)
  );

`ifdef SEG7_READER_BLANK_EN
  assign is_blank = (seg_q == SEG_BLANK);
`else
  assign is_blank = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Sequence tracking FSM
  // ---------------------------------------------------------------------------
  seg7_state_t state;
  seg7_state_t next_state;
  logic [3:0]  prev;
  logic [3:0]  prev_inc;

  logic       valid_d;
  logic       inv_d;
  logic       seq_d;
  logic [3:0] digit_d;
  logic [3:0] prev_d;

  assign prev_inc = prev + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= NO_REF;
    end else begin
      state <= next_state;
    end
  end

  // Blank and illegal patterns both drop the reference; only a legal digit
  // establishes or keeps one.
  always_comb begin
    next_state = state;
    if (accept) begin
      if (pat_legal) begin
        next_state = TRACK;
      end else begin
        next_state = NO_REF;
      end
    end
  end

  always_comb begin
    valid_d = 1'b0;
    inv_d   = 1'b0;
    seq_d   = 1'b0;
    digit_d = digit_out;
    prev_d  = prev;
    if (accept) begin
      if (pat_legal) begin
        valid_d = 1'b1;
        digit_d = pat_digit;
        prev_d  = pat_digit;
        if ((state == TRACK) && (pat_digit != prev_inc)) begin
          seq_d = 1'b1;
        end
      end else if (!is_blank) begin
        inv_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs, error counter, stall detection
  // ---------------------------------------------------------------------------
  logic [23:0] stall_cnt;
  logic [23:0] stall_nxt;

  always_comb begin
    stall_nxt = stall_cnt;
    if (accept) begin
      stall_nxt = 24'd0;
    end else if (stall_cnt != STALL_LIMIT) begin
      stall_nxt = stall_cnt + 24'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_out     <= 4'h0;
      digit_valid   <= 1'b0;
      invalid_pulse <= 1'b0;
      seq_err       <= 1'b0;
      prev          <= 4'h0;
      err_count     <= 8'h00;
      stall_cnt     <= 24'd0;
      stall         <= 1'b0;
    end else begin
      digit_out     <= digit_d;
      digit_valid   <= valid_d;
      invalid_pulse <= inv_d;
      seq_err       <= seq_d;
      prev          <= prev_d;
      // inv_d and seq_d are mutually exclusive, so at most +1 per cycle.
      if ((inv_d || seq_d) && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
      stall_cnt <= stall_nxt;
      stall     <= (stall_nxt == STALL_LIMIT);
    end
  end

endmodule

// File: tb/tb_seg7_reader.sv
// tb/tb_seg7_reader.sv - scoreboard bench for seg7_reader

module tb_seg7_reader;

  localparam int          STABLE = 4;
  localparam logic [23:0] LIMIT  = 24'd100;
`ifdef SEG7_READER_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg_in = 7'h3F;
  logic [3:0] digit_out;
  logic       digit_valid;
  logic       invalid_pulse;
  logic       seq_err;
  logic       stall;
  logic [7:0] err_count;

  seg7_reader #(
    .STABLE_CYCLES (STABLE),
    .STALL_LIMIT   (LIMIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .seg_in        (seg_in),
    .digit_out     (digit_out),
    .digit_valid   (digit_valid),
    .invalid_pulse (invalid_pulse),
    .seq_err       (seq_err),
    .stall         (stall),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Independent digit->pattern table.
  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    int         cyc;
    logic       inv;
    logic       seq;
    logic [3:0] dig;
    logic [7:0] errc;
  } exp_t;

  exp_t sb[$];

  // Reference model state.
  bit         m_have;
  logic [6:0] m_last;
  bit         m_track;
  logic [3:0] m_prev;
  logic [3:0] m_digit;
  logic [7:0] m_errc;

  task automatic model_reset();
    m_have  = 0;
    m_last  = 7'h00;
    m_track = 0;
    m_prev  = 4'h0;
    m_digit = 4'h0;
    m_errc  = 8'h00;
  endtask

  // Called right after a falling edge: drive pattern for n cycles and
  // predict the resulting pulse (if any).
  task automatic present(input logic [6:0] pat, input int n);
    bit         legal;
    logic [3:0] dig;
    logic [3:0] nxt;
    exp_t       e;
    seg_in = pat;
    if (n >= STABLE && (!m_have || pat != m_last)) begin
      m_have = 1;
      m_last = pat;
      legal  = 0;
      dig    = 4'h0;
      for (int i = 0; i < 16; i++) begin
        if (tbl[i] == pat) begin
          legal = 1;
          dig   = 4'(i);
        end
      end
      e.cyc = cyc + STABLE + 1;
      if (legal) begin
        nxt   = m_prev + 4'd1;
        e.seq = m_track && (dig != nxt);
        e.inv = 1'b0;
        if (e.seq && m_errc != 8'hFF) m_errc = m_errc + 8'd1;
        m_digit = dig;
        m_prev  = dig;
        m_track = 1;
        e.dig   = m_digit;
        e.errc  = m_errc;
        sb.push_back(e);
      end else if (BLANK_EN && pat == 7'h00) begin
        m_track = 0;
      end else begin
        m_track = 0;
        if (m_errc != 8'hFF) m_errc = m_errc + 8'd1;
        e.inv  = 1'b1;
        e.seq  = 1'b0;
        e.dig  = m_digit;
        e.errc = m_errc;
        sb.push_back(e);
      end
    end
  endtask

  task automatic drive(input logic [6:0] pat, input int n);
    present(pat, n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [6:0] pat);
    check_eq("sb_drained_before_reset", sb.size(), 0);
    seg_in = pat;
    rst    = 1'b1;
    @(negedge clk);
    check_eq("rst_digit_out", digit_out, 0);
    check_eq("rst_digit_valid", digit_valid, 0);
    check_eq("rst_invalid_pulse", invalid_pulse, 0);
    check_eq("rst_seq_err", seq_err, 0);
    check_eq("rst_stall", stall, 0);
    check_eq("rst_err_count", err_count, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (!rst) begin
      if (digit_valid || invalid_pulse) begin
        if (sb.size() == 0) begin
          check_eq("spurious_pulse", {30'd0, digit_valid, invalid_pulse}, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("pulse_cycle", cyc, e.cyc);
          check_eq("digit_valid", digit_valid, !e.inv);
          check_eq("invalid_pulse", invalid_pulse, e.inv);
          check_eq("seq_err", seq_err, e.seq);
          check_eq("digit_out", digit_out, e.dig);
          check_eq("err_count", err_count, e.errc);
          check_eq("stall_on_accept", stall, 0);
        end
      end else if (seq_err) begin
        check_eq("seq_err_without_valid", seq_err, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int start;

  initial begin
    model_reset();
    @(negedge clk);
    // Reset state and first acceptance
    do_reset(7'h3F);
    drive(7'h3F, 10);
    check_eq("first_digit_out", digit_out, 0);

    // Full count 1..F then wrap to 0
    for (int i = 1; i <= 16; i++) drive(tbl[i % 16], 8);

    // Glitch shorter than the qualification window
    drive(7'h06, 3);
    drive(7'h3F, 6);
    drive(7'h06, 4);
    drive(7'h5B, 8);
    check_eq("digit_after_glitch", digit_out, 2);

    // Sequence error, illegal pattern, recovery without reference
    do_reset(7'h3F);
    drive(7'h3F, 8);
    drive(7'h5B, 8);
    drive(7'h01, 8);
    drive(7'h4F, 8);
    check_eq("err_count_after_errors", err_count, 2);

    // Stall detection and reset mid-run
    do_reset(7'h3F);
    start = cyc;
    present(7'h3F, 150);
    repeat (STABLE + 100) @(negedge clk);
    check_eq("stall_before_limit", stall, 0);
    @(negedge clk);
    check_eq("stall_at_limit", stall, 1);
    repeat (150 - STABLE - 101) @(negedge clk);
    check_eq("stall_held", stall, 1);
    present(7'h06, 14);
    repeat (STABLE) @(negedge clk);
    check_eq("stall_before_accept", stall, 1);
    repeat (10) @(negedge clk);
    do_reset(7'h06);
    drive(7'h06, 10);
    check_eq("reaccept_digit", digit_out, 1);

    // Blank pattern handling
    do_reset(7'h3F);
    drive(7'h3F, 8);
    drive(7'h00, 8);
    drive(7'h5B, 8);
    check_eq("blank_err_count", err_count, BLANK_EN ? 0 : 1);

    repeat (10) @(negedge clk);
    check_eq("sb_empty_end", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
